// File: rtl/acc32_pkg.sv
// acc32_pkg: shared state encoding and default sizing for the acc32_rd stream accumulator.
package acc32_pkg;
    typedef enum logic {ACC, DONE} acc_state_e;
    localparam int ACC_WIDTH = 32;
    localparam int ACC_CNT_W = 8;
    localparam logic [ACC_WIDTH-1:0] ACC_ALL_ONES = '1;
endpackage

// File: rtl/adder32bit.sv
// adder32bit: recursive-doubling (Kogge-Stone) parallel-prefix adder.
module adder32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] p, g, pg, gn, pn;
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        g[0] = g[0] | (p[0] & cin);
        pg = p;
        gn = g;
        pn = pg;
        // each pass doubles the span over which group generate/propagate is known
        for (int k = 1; k < WIDTH; k = k * 2) begin
            gn = g;
            pn = pg;
            for (int i = k; i < WIDTH; i++) begin
                gn[i] = g[i] | (pg[i] & g[i-k]);
                pn[i] = pg[i] & pg[i-k];
            end
            g  = gn;
            pg = pn;
        end
    end
    assign sum  = p ^ {g[WIDTH-2:0], cin};
    assign cout = g[WIDTH-1];
endmodule

// File: rtl/acc32_rd.sv
// acc32_rd: framed valid/ready stream accumulator around one adder32bit.
// Define ACC_SAT_EN to clamp the running sum to all ones once it overflows.
module acc32_rd
    import acc32_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);
    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, add_sum, next_acc;
    logic             carry_q, carry_d, add_cout;
    logic [CNT_W-1:0] count_q, count_d;

    adder32bit #(.WIDTH(WIDTH)) u_add (
        .a(acc_q), .b(in_data), .cin(1'b0), .sum(add_sum), .cout(add_cout)
    );

`ifdef ACC_SAT_EN
    assign next_acc = (add_cout || carry_q) ? WIDTH'(ACC_ALL_ONES) : add_sum;
`else
    assign next_acc = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        if (clr || (state_q == DONE && out_ready)) begin
            state_d = ACC;
            acc_d   = '0;
            carry_d = 1'b0;
            count_d = '0;
        end else if (state_q == ACC && in_valid) begin
            acc_d   = next_acc;
            carry_d = carry_q | add_cout;
            count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
            state_d = in_last ? DONE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    // the accumulator is frozen in DONE, so it doubles as the result register
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_carry = out_valid & carry_q;
    assign out_count = out_valid ? count_q : '0;
endmodule

// File: tb/tb_acc32_rd.sv
// tb_acc32_rd: directed self-checking bench for acc32_rd.
module tb_acc32_rd;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_carry;
    logic [31:0] out_sum;
    logic [7:0]  out_count;
    int          n_cmp = 0, n_bad = 0;

    acc32_rd dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] s, input logic c, input logic [7:0] n);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_sum"}, 64'(out_sum), 64'(s));
        chk({tag, "_carry"}, 64'(out_carry), 64'(c));
        chk({tag, "_count"}, 64'(out_count), 64'(n));
    endtask

    initial begin
        logic [31:0] ovf_sum;
`ifdef ACC_SAT_EN
        ovf_sum = 32'hffffffff;
`else
        ovf_sum = 32'd54;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(out_sum), 64'(0));
        chk("rst_carry", 64'(out_carry), 64'(0));
        chk("rst_count", 64'(out_count), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(1));

        beat(32'd10, 1'b0);
        chk("f1_mid_valid", 64'(out_valid), 64'(0));
        beat(32'd10, 1'b1);
        result("f1", 32'd20, 1'b0, 8'd2);
        chk("f1_busy", 64'(in_ready), 64'(0));
        take();
        chk("f1_drop", 64'(out_valid), 64'(0));
        chk("f1_ready", 64'(in_ready), 64'(1));

        beat(32'd200, 1'b0);
        beat(32'd750, 1'b0);
        beat(32'd1234, 1'b0);
        beat(32'd5678, 1'b1);
        result("f2", 32'd7862, 1'b0, 8'd4);
        take();

        beat(32'hffffffff, 1'b0);
        beat(32'd55, 1'b1);
        result("ovf", ovf_sum, 1'b1, 8'd2);
        take();

        beat(32'd5, 1'b0);
        beat(32'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd999 + 32'(i);
            in_last  = 1'b1;
            @(negedge clk);
            result("bp", 32'd11, 1'b0, 8'd2);
            chk("bp_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        chk("bp_taken", 64'(out_valid), 64'(0));

        beat(32'h12345678, 1'b1);
        result("single", 32'h12345678, 1'b0, 8'd1);
        take();

        beat(32'd100, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 32'd7;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'(0));
        chk("clr_ready", 64'(in_ready), 64'(1));
        beat(32'd3, 1'b1);
        result("clr", 32'd3, 1'b0, 8'd1);
        take();

        beat(32'd9, 1'b1);
        chk("clrd_pre", 64'(out_valid), 64'(1));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clrd_valid", 64'(out_valid), 64'(0));
        chk("clrd_sum", 64'(out_sum), 64'(0));
        chk("clrd_count", 64'(out_count), 64'(0));
        beat(32'd4, 1'b1);
        result("clrd", 32'd4, 1'b0, 8'd1);
        take();

        beat(32'd100, 1'b0);
        beat(32'd50, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_sum", 64'(out_sum), 64'(0));
        chk("arst_count", 64'(out_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        beat(32'd100, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        beat(32'd3, 1'b1);
        result("arst", 32'd3, 1'b0, 8'd1);
        take();

        for (int i = 0; i < 256; i++) beat(32'd1, i == 255);
        result("cntsat", 32'd256, 1'b0, 8'd255);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc32_rd.md
Name: acc32_rd

Overview:
- Sequential 32-bit stream accumulator that sits directly downstream of the recursive-doubling adder (`adder32bit`) in the Dadda multiplier datapath.
- Accepts a framed stream of operands over a valid/ready handshake and sums each frame, one operand per cycle, in a registered accumulator.
- Uses one `adder32bit` instance with cin=0 for each add.
- Presents the frame total, a sticky carry-out flag and a beat count on an output valid/ready handshake.

Parameters:
- WIDTH, 32, operand/accumulator width; must match the `adder32bit` width.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous frame abort/clear
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  WIDTH  operand
- in_last  input  1  operand is the final beat of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  WIDTH  frame total (low WIDTH bits)
- out_carry  output  1  sticky OR of every adder cout in the frame
- out_count  output  CNT_W  beats accumulated in the frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to ACC.
  - acc, carry and count clear to 0.
  - out_valid=0, out_sum=0, out_carry=0, out_count=0.
  - in_ready is 1 after reset deasserts.
  - Reset mid-frame discards all partial state.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Beat acceptance (in_valid && in_ready, in ACC):
  - acc <= adder32bit(acc, in_data, 0).sum.
  - carry <= carry | cout.
  - count <= count+1, saturating at 2^CNT_W-1.
- Last beat (accepted beat with in_last=1):
  - out_sum, out_carry and out_count load the post-add values.
  - State goes to DONE; out_valid rises on the next cycle (latency 1 from the last beat).
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: acc, carry and count clear, state returns to ACC, and in_ready=1 on the next cycle. This gives one bubble cycle per frame.
- Single-beat frame (first beat has in_last=1): out_sum=in_data, out_carry=0, out_count=1.
- clr=1 (highest priority after reset):
  - acc, carry and count clear and state goes to ACC; any beat presented in the same cycle is dropped.
  - In DONE, the pending result is discarded: out_valid falls on the next cycle and out_sum/out_carry/out_count return to 0.
- in_data is ignored whenever in_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH unless ACC_SAT_EN is defined; out_carry still records the overflow.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: when an accepted beat produces cout=1 or carry is already set, acc becomes all ones (2^WIDTH-1) and stays there for the rest of the frame. out_carry behaves as without the macro.
- Undefined: wrapping modulo addition as described above.

Decomposition:
- Shared package `acc32_pkg` holds:
  - the state enum (ACC, DONE);
  - default WIDTH/CNT_W constants;
  - the all-ones saturation constant.
- Natural sub-module: existing `adder32bit` (a, b, cin, sum, cout), instantiated once. No other sub-module.

Test Plan:
- Frame 10, 10 (last), out_ready=1 -> out_valid one cycle after the last beat; out_sum=20, out_carry=0, out_count=2; in_ready back to 1 one cycle after the handshake.
- Frame 200, 750, 1234, 5678 (last) -> out_sum=7862, out_carry=0, out_count=4.
- Frame 32'hffffffff, 55 (last):
  - macro undefined -> out_sum=54, out_carry=1.
  - ACC_SAT_EN defined -> out_sum=32'hffffffff, out_carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_sum/out_carry/out_count stable, in_ready=0 throughout, in_data changes ignored; result consumed on the first out_ready=1.
- Abort and reset:
  - Accept 100, then clr=1 with in_valid=1, in_data=7 -> beat dropped; next frame 3 (last) gives out_sum=3, out_count=1.
  - Repeat with rst_n pulsed low mid-frame -> all outputs 0 immediately.
- Single-beat frame 32'h12345678 with in_last=1 on the first beat -> out_sum=32'h12345678, out_count=1, out_carry=0.
